// File: rtl/core_decode_queue.sv
// ---------------------------------------------------------------------------
// core_decode_queue
//   Buffered decode stage. A DEPTH-entry FIFO of raw {insn, pc} pairs sits
//   between fetch and a registered decode output, so decode stalls do not
//   back up into fetch. With SKIP_NOP set, NOPs are accepted and dropped
//   before they take a FIFO slot.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   in_valid/in_ready/insn/insn_pc   fetch handshake and payload
//   stall         downstream not consuming; dec holds
//   flush         discard queue and output (branch redirect)
//   out_valid/dec registered decode of the oldest instruction
//   level         FIFO occupancy (output register excluded)
//   almost_full   level >= AFULL
// ---------------------------------------------------------------------------
package core_decode_queue_pkg;
   localparam int unsigned HWORD_W = 32;
   localparam int unsigned HPTR_W  = 32;

   typedef logic [HWORD_W-1:0] hword;
   typedef logic [HPTR_W-1:0]  hptr;

   // ISA groups live in insn[31:28]; anything not listed does not execute.
   typedef enum logic [3:0] {
      GRP_SYS    = 4'd0,
      GRP_ALU    = 4'd1,
      GRP_LOAD   = 4'd2,
      GRP_STORE  = 4'd3,
      GRP_BRANCH = 4'd4
   } isa_group_e;

   typedef struct packed {
      logic execute;
      logic alu;
      logic load;
      logic store;
      logic branch;
   } insn_ctrl_t;

   // Field layout: group[31:28] rd[27:23] rs1[22:18] rs2[17:13] imm[12:0].
   typedef struct packed {
      insn_ctrl_t  ctrl;
      logic [3:0]  group;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [12:0] imm;
      hptr         pc;
   } insn_decode;
endpackage

module core_decode_queue
   import core_decode_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter bit          SKIP_NOP = 1'b1,
   parameter int unsigned AFULL    = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  hword                       insn,
   input  hptr                        insn_pc,
   input  logic                       stall,
   input  logic                       flush,
   output logic                       out_valid,
   output insn_decode                 dec,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       almost_full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   typedef struct packed {
      hword insn;
      hptr  pc;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   insn_decode       dec_q, dec_d;
   logic             out_valid_q, out_valid_d;

   logic accept, store_ok, advance, pop, bypass, push;

   // NOP is the all-zero word and decodes to the all-zero record (pc included).
   function automatic insn_decode decode_insn(input hword w, input hptr p);
      insn_decode d;
      d = '0;
      if (w != '0) begin
         d.group = w[31:28];
         d.rd    = w[27:23];
         d.rs1   = w[22:18];
         d.rs2   = w[17:13];
         d.imm   = w[12:0];
         d.pc    = p;
         case (w[31:28])
            GRP_ALU:    begin d.ctrl.alu    = 1'b1; d.ctrl.execute = 1'b1; end
            GRP_LOAD:   begin d.ctrl.load   = 1'b1; d.ctrl.execute = 1'b1; end
            GRP_STORE:  begin d.ctrl.store  = 1'b1; d.ctrl.execute = 1'b1; end
            GRP_BRANCH: begin d.ctrl.branch = 1'b1; d.ctrl.execute = 1'b1; end
            default:    d.ctrl = '0;
         endcase
      end
      return d;
   endfunction

   // Ready comes from the registered count only; a pop in a full cycle does
   // not open a slot, which keeps stall off the in_ready path.
   assign in_ready = !rst && !flush && (level_q < LVL_W'(DEPTH));
   assign accept   = in_valid && in_ready;
   assign store_ok = accept && !(SKIP_NOP && (insn == '0));
   assign advance  = !stall || !out_valid_q;
   assign pop      = advance && (level_q != '0);
   // Empty FIFO and advancing: the input goes straight to dec, never stored.
   assign bypass   = advance && (level_q == '0) && store_ok;
   assign push     = store_ok && !bypass;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      dec_d       = dec_q;
      out_valid_d = out_valid_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         dec_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         level_d = level_q + LVL_W'(push) - LVL_W'(pop);
         if (advance) begin
            if (pop) begin
               dec_d       = decode_insn(mem_q[rd_ptr_q].insn, mem_q[rd_ptr_q].pc);
               out_valid_d = 1'b1;
            end else if (bypass) begin
               dec_d       = decode_insn(insn, insn_pc);
               out_valid_d = 1'b1;
            end else begin
               dec_d       = '0;
               out_valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         dec_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         dec_q       <= dec_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Storage needs no reset; push is already blocked under rst and flush.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{insn: insn, pc: insn_pc};
   end

   assign out_valid   = out_valid_q;
   assign dec         = dec_q;
   assign level       = level_q;
   assign almost_full = (level_q >= LVL_W'(AFULL));

endmodule
